// File: rtl/reload_sequencer_if.sv
// Reload sequencer bus: table write port, run control, timer link
// and sequencing status outputs.
interface reload_sequencer_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [1:0] len;
    logic       start;
    logic       stop;
    logic [3:0] q_in;
    logic [3:0] d_out;
    logic [1:0] slot;
    logic       running;
    logic       epoch_done;
    logic [7:0] epochs;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output len,
        output start,
        output stop,
        output q_in,
        input  d_out,
        input  slot,
        input  running,
        input  epoch_done,
        input  epochs
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  len,
        input  start,
        input  stop,
        input  q_in,
        output d_out,
        output slot,
        output running,
        output epoch_done,
        output epochs
    );
endinterface

// File: rtl/reload_sequencer.sv
// Steps a countdown timer through a 4-entry reload table, one entry
// per timer expiry, counting completed passes through the table.
module reload_sequencer (
    input  logic              clk,
    input  logic              reset,
    reload_sequencer_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] slot_r;
    logic [1:0] len_r;
    logic [3:0] tbl [4];
    logic [7:0] epochs_r;
    logic       done_r;
    logic       reload;
    logic       wrap;

    // The timer reloads from d_out on the same edge it reads zero.
    assign reload = (state == RUN) && !bus.stop
                    && (bus.q_in == 4'h0);
    assign wrap   = (slot_r == len_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            slot_r   <= 2'd0;
            len_r    <= 2'd0;
            epochs_r <= 8'h00;
            done_r   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tbl[i] <= 4'h0;
            end
        end else begin
            if (bus.wr_en) begin
                tbl[bus.wr_addr] <= bus.wr_data;
            end
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state    <= RUN;
                        slot_r   <= 2'd0;
                        len_r    <= bus.len;
                        epochs_r <= 8'h00;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        slot_r <= 2'd0;
                    end else if (reload) begin
                        slot_r <= wrap ? 2'd0 : slot_r + 2'd1;
                        if (wrap) begin
                            done_r <= 1'b1;
                            if (epochs_r != 8'hFF) begin
                                epochs_r <= epochs_r + 8'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Parking at zero in IDLE keeps the attached timer at rest.
    assign bus.d_out      = (state == RUN) ? tbl[slot_r] : 4'h0;
    assign bus.slot       = slot_r;
    assign bus.running    = (state == RUN);
    assign bus.epoch_done = done_r;
    assign bus.epochs     = epochs_r;
endmodule

// File: tb/tb_reload_sequencer.sv
// Self-checking bench for reload_sequencer: attached countdown timer
// plus a rule-level reference model of the sequencer.
module tb_reload_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reload_sequencer_if bus ();

    reload_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit use_timer;

    bit         m_run;
    logic [1:0] m_slot;
    logic [1:0] m_len;
    logic [3:0] m_tab [4];
    logic [7:0] m_epochs;
    bit         m_done;
    logic [3:0] m_q;

    function automatic logic [3:0] m_dout();
        return m_run ? m_tab[m_slot] : 4'h0;
    endfunction

    // One clock: timer loads DUT d_out on zero, model follows the rules.
    task automatic tick();
        logic [3:0] d_now;
        d_now = bus.d_out;
        @(posedge clk);
        m_q = (m_q == 4'h0) ? d_now : m_q - 4'h1;
        if (reset) begin
            m_run = 0; m_slot = 0; m_len = 0;
            m_epochs = 0; m_done = 0;
            for (int i = 0; i < 4; i++) m_tab[i] = 4'h0;
        end else begin
            logic fire;
            fire = m_run && !bus.stop && (bus.q_in == 4'h0);
            if (bus.wr_en) m_tab[bus.wr_addr] = bus.wr_data;
            m_done = 0;
            if (bus.stop) begin
                m_run = 0;
                m_slot = 0;
            end else if (!m_run && bus.start) begin
                m_run = 1;
                m_slot = 0;
                m_len = bus.len;
                m_epochs = 0;
            end else if (fire) begin
                if (m_slot == m_len) begin
                    m_slot = 0;
                    m_done = 1;
                    if (m_epochs != 8'hFF) m_epochs = m_epochs + 8'd1;
                end else begin
                    m_slot = m_slot + 2'd1;
                end
            end
        end
        #1;
        if (use_timer) bus.q_in = m_q;
    endtask

    task automatic quiet();
        bus.wr_en = 0;
        bus.start = 0;
        bus.stop  = 0;
    endtask

    task automatic stop_and_park();
        quiet();
        bus.stop = 1;
        tick();
        bus.stop = 0;
        repeat (16) tick();
    endtask

    task automatic load_table(input logic [3:0] v0, input logic [3:0] v1,
                              input logic [3:0] v2, input logic [3:0] v3);
        logic [3:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1;
            bus.wr_addr = 2'(i);
            bus.wr_data = v[i];
            tick();
        end
        bus.wr_en = 0;
    endtask

    task automatic go(input logic [1:0] l);
        bus.len   = l;
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        quiet();
        use_timer = 1;
        bus.len = 2'd3;
        bus.wr_addr = 0;
        bus.wr_data = 0;
        bus.q_in = 0;
        m_q = 0;
        tick();
        bus.start = 1;
        bus.wr_en = 1;
        tick();
        quiet();
        reset = 0;
        checks++;
        if (bus.running !== 1'b0 || bus.slot !== 2'd0 ||
            bus.d_out !== 4'h0 || bus.epochs !== 8'h00 ||
            bus.epoch_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: run=%b slot=%0d d=%0h ep=%0d done=%b, want all 0",
                     bus.running, bus.slot, bus.d_out, bus.epochs,
                     bus.epoch_done);
        end
        go(2'd3);
        begin
            int pulses = 0;
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (bus.d_out !== 4'h0) begin
                    errors++;
                    $display("FAIL reset_table: d_out=%0h want 0", bus.d_out);
                end
                tick();
                if (bus.epoch_done === 1'b1) pulses++;
            end
            checks++;
            if (pulses != 3) begin
                errors++;
                $display("FAIL reset_len3_pulses: got %0d want 3", pulses);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp_q [11];
        int last;
        int pulses;
        exp_q = '{0, 3, 2, 1, 0, 1, 0, 2, 1, 0, 3};
        stop_and_park();
        load_table(4'd3, 4'd1, 4'd2, 4'd9);
        repeat (16) tick();
        go(2'd2);
        last = -1;
        pulses = 0;
        for (int k = 0; k < 45; k++) begin
            if (k < 11) begin
                checks++;
                if (bus.q_in !== exp_q[k]) begin
                    errors++;
                    $display("FAIL basic_q[%0d]: got %0d want %0d",
                             k, bus.q_in, exp_q[k]);
                end
            end
            checks++;
            if (bus.d_out !== m_dout() || bus.slot !== m_slot ||
                bus.epochs !== m_epochs) begin
                errors++;
                $display("FAIL basic_k%0d: d=%0h/%0h slot=%0d/%0d ep=%0d/%0d (got/want)",
                         k, bus.d_out, m_dout(), bus.slot, m_slot,
                         bus.epochs, m_epochs);
            end
            if (bus.epoch_done === 1'b1) begin
                pulses++;
                checks++;
                if ((last >= 0 && k - last != 9) ||
                    bus.epochs !== 8'(pulses)) begin
                    errors++;
                    $display("FAIL basic_epoch: gap=%0d want 9, epochs=%0d want %0d",
                             k - last, bus.epochs, pulses);
                end
                last = k;
            end
            tick();
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL basic_pulses: got %0d want 5", pulses);
        end
    endtask

    task automatic test_zero_entry();
        int last;
        int pulses;
        stop_and_park();
        load_table(4'd0, 4'd2, 4'd0, 4'd0);
        repeat (4) tick();
        go(2'd1);
        checks++;
        if (bus.slot !== 2'd0 || bus.q_in !== 4'h0) begin
            errors++;
            $display("FAIL zero_first: slot=%0d q=%0d want 0/0",
                     bus.slot, bus.q_in);
        end
        tick();
        checks++;
        if (bus.slot !== 2'd1) begin
            errors++;
            $display("FAIL zero_advance: slot=%0d want 1", bus.slot);
        end
        last = -1;
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            if (bus.epoch_done === 1'b1) begin
                pulses++;
                checks++;
                if (last >= 0 && k - last != 4) begin
                    errors++;
                    $display("FAIL zero_period: gap=%0d want 4", k - last);
                end
                last = k;
            end
            checks++;
            if (bus.epoch_done !== m_done || bus.slot !== m_slot) begin
                errors++;
                $display("FAIL zero_k%0d: done=%b/%b slot=%0d/%0d (got/want)",
                         k, bus.epoch_done, m_done, bus.slot, m_slot);
            end
            tick();
        end
        checks++;
        if (pulses != 6) begin
            errors++;
            $display("FAIL zero_pulses: got %0d want 6", pulses);
        end
    endtask

    task automatic test_collision();
        stop_and_park();
        bus.start = 1;
        bus.stop = 1;
        tick();
        quiet();
        checks++;
        if (bus.running !== 1'b0 || bus.slot !== 2'd0 ||
            bus.d_out !== 4'h0) begin
            errors++;
            $display("FAIL coll_idle: run=%b slot=%0d d=%0h want 0/0/0",
                     bus.running, bus.slot, bus.d_out);
        end
        load_table(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (4) tick();
        go(2'd3);
        repeat (3) tick();
        bus.len = 2'd0;
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (bus.running !== 1'b1 || bus.slot !== m_slot ||
                bus.epoch_done !== m_done) begin
                errors++;
                $display("FAIL run_start_ignored k%0d: run=%b slot=%0d/%0d done=%b/%b",
                         k, bus.running, bus.slot, m_slot,
                         bus.epoch_done, m_done);
            end
            tick();
        end
        bus.start = 1;
        bus.stop = 1;
        tick();
        quiet();
        checks++;
        if (bus.running !== 1'b0 || bus.slot !== 2'd0 ||
            bus.d_out !== 4'h0) begin
            errors++;
            $display("FAIL coll_run: run=%b slot=%0d d=%0h want 0/0/0",
                     bus.running, bus.slot, bus.d_out);
        end
    endtask

    task automatic test_saturation();
        stop_and_park();
        load_table(4'd0, 4'd7, 4'd7, 4'd7);
        go(2'd0);
        for (int k = 0; k < 300; k++) begin
            tick();
            checks++;
            if (bus.epoch_done !== 1'b1 || bus.epochs !== m_epochs) begin
                errors++;
                $display("FAIL sat_k%0d: done=%b want 1, ep=%0d want %0d",
                         k, bus.epoch_done, bus.epochs, m_epochs);
            end
        end
        checks++;
        if (bus.epochs !== 8'hFF) begin
            errors++;
            $display("FAIL sat_final: epochs=%0h want ff", bus.epochs);
        end
    endtask

    task automatic test_reset_live();
        int budget;
        stop_and_park();
        load_table(4'd3, 4'd1, 4'd2, 4'd6);
        repeat (4) tick();
        go(2'd2);
        budget = 50;
        while (bus.slot !== 2'd1 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL live_wait_slot1: slot=%0d want 1", bus.slot);
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (bus.running !== 1'b0 || bus.slot !== 2'd0 ||
            bus.d_out !== 4'h0 || bus.epochs !== 8'h00 ||
            bus.epoch_done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: run=%b slot=%0d d=%0h ep=%0d done=%b",
                     bus.running, bus.slot, bus.d_out, bus.epochs,
                     bus.epoch_done);
        end
        repeat (16) tick();
        load_table(4'd3, 4'd1, 4'd2, 4'd4);
        go(2'd3);
        repeat (5) tick();
        budget = 50;
        while (bus.q_in === 4'h0 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL live_wait_busy: q=%0d want nonzero", bus.q_in);
        end
        bus.wr_en = 1;
        bus.wr_addr = m_slot;
        bus.wr_data = 4'd5;
        tick();
        bus.wr_en = 0;
        checks++;
        if (bus.d_out !== 4'd5) begin
            errors++;
            $display("FAIL live_update: d_out=%0d want 5", bus.d_out);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) use_timer = ($urandom_range(0, 1) == 1);
            reset       = ($urandom_range(0, 99) == 0);
            bus.stop    = ($urandom_range(0, 29) == 0);
            bus.start   = ($urandom_range(0, 9) == 0);
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 2'($urandom);
            bus.wr_data = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            bus.len     = 2'($urandom);
            if (!use_timer)
                bus.q_in = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom);
            tick();
            checks++;
            if (bus.running !== m_run || bus.slot !== m_slot ||
                bus.d_out !== m_dout() || bus.epochs !== m_epochs ||
                bus.epoch_done !== m_done) begin
                errors++;
                $display("FAIL rand_k%0d: run=%b/%b slot=%0d/%0d d=%0h/%0h ep=%0d/%0d done=%b/%b",
                         k, bus.running, m_run, bus.slot, m_slot,
                         bus.d_out, m_dout(), bus.epochs, m_epochs,
                         bus.epoch_done, m_done);
            end
        end
        reset = 0;
        quiet();
        use_timer = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_entry();
        test_collision();
        test_saturation();
        test_reset_live();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
